// File: rtl/tpu_pkg.sv
// Shared definitions for the tpumac systolic array, its feeders and the drain/collector stages.
//   DIM_DEFAULT : default array edge length
//   BITS_AB     : signed operand width per lane (tpumac Ain/Bin)
//   BITS_C      : accumulator width (tpumac Cout)
//   feeder_state_t : skew feeder FSM states
package tpu_pkg;

    localparam int unsigned DIM_DEFAULT = 8;
    localparam int unsigned BITS_AB     = 8;
    localparam int unsigned BITS_C      = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } feeder_state_t;

endpackage

// File: rtl/skew_lane.sv
// One lane of the skew feeder: a DEPTH-stage shift register that advances only when adv is high.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears every stage
//   adv   : shift enable; all stages hold when low
//   d     : lane input
//   q     : oldest stage, DEPTH advance cycles behind d
module skew_lane #(
    parameter int unsigned DEPTH   = 1,
    parameter int unsigned BITS_AB = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv,
    input  logic [BITS_AB-1:0] d,
    output logic [BITS_AB-1:0] q
);

    logic [BITS_AB-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage_q[k] <= '0;
            end
        end else if (adv) begin
            stage_q[0] <= d;
            for (int k = 1; k < int'(DEPTH); k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Upstream feeder for the tpumac systolic array. Accepts one DIM-lane row per handshake beat,
// delays lane i by i+1 advance cycles so the row enters the array diagonally, then injects
// DIM-1 zero beats to drain the diagonal and pulses done with the final array enable.
//   clk, rst_n         : clock and asynchronous active-low reset
//   in_valid/in_ready  : upstream row handshake; in_last marks the last row of a tile
//   in_data            : packed row, lane i = [i*BITS_AB +: BITS_AB]
//   out_data           : skewed lanes to the array edge, held while out_en is low
//   out_en             : array enable, high in the cycle after each advance
//   done               : one-cycle pulse coincident with the last out_en of a tile
//   tile_err           : sticky tile-length error
// Optional: define SKEW_TILE_CHECK_EN to build the beat counter and tile_err checking;
// otherwise tile_err is tied low.
module systolic_skew_feeder #(
    parameter int unsigned DIM     = tpu_pkg::DIM_DEFAULT,
    parameter int unsigned BITS_AB = tpu_pkg::BITS_AB
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [DIM*BITS_AB-1:0] in_data,
    output logic [DIM*BITS_AB-1:0] out_data,
    output logic                   out_en,
    output logic                   done,
    output logic                   tile_err
);

    import tpu_pkg::*;

    localparam int unsigned FlushW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [FlushW-1:0] FlushLast = FlushW'((DIM > 1) ? DIM - 2 : 0);

    feeder_state_t     state_q, state_d;
    logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
    logic              out_en_q;
    logic              done_q, done_d;
    logic              accept;
    logic              advance;
    logic              flushing;

    assign flushing = (state_q == FLUSH);
    // Gated by rst_n so upstream never sees a ready while the feeder is held in reset.
    assign in_ready = rst_n && !flushing;
    assign accept   = in_valid && in_ready;
    assign advance  = accept || flushing;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (!in_last) begin
                        state_d = STREAM;
                    end else if (DIM == 1) begin
                        // A single lane has no diagonal to drain.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = FLUSH;
                        flush_cnt_d = '0;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FlushLast) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            out_en_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            out_en_q    <= advance;
            done_q      <= done_d;
        end
    end

    assign out_en = out_en_q;
    assign done   = done_q;

    for (genvar i = 0; i < int'(DIM); i++) begin : g_lane
        logic [BITS_AB-1:0] lane_d;
        // Zeros are shifted in while draining.
        assign lane_d = flushing ? '0 : in_data[i*BITS_AB +: BITS_AB];

        skew_lane #(
            .DEPTH   (i + 1),
            .BITS_AB (BITS_AB)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (advance),
            .d     (lane_d),
            .q     (out_data[i*BITS_AB +: BITS_AB])
        );
    end

`ifdef SKEW_TILE_CHECK_EN
    localparam int unsigned BeatW = $clog2(DIM + 1);

    logic [BeatW-1:0] beat_cnt_q;
    logic [BeatW:0]   beat_inc;
    logic             tile_err_q;

    assign beat_inc = {1'b0, beat_cnt_q} + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            tile_err_q <= 1'b0;
        end else begin
            if (done_d) begin
                beat_cnt_q <= '0;
            end else if (accept && (beat_inc <= (BeatW+1)'(DIM))) begin
                // Saturates at DIM so an over-long tile cannot wrap back to a legal count.
                beat_cnt_q <= beat_inc[BeatW-1:0];
            end
            if (accept && in_last && (beat_inc != (BeatW+1)'(DIM))) begin
                tile_err_q <= 1'b1;
            end
            if (accept && !in_last && (beat_inc == (BeatW+1)'(DIM))) begin
                tile_err_q <= 1'b1;
            end
        end
    end

    assign tile_err = tile_err_q;
`else
    assign tile_err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: a DIM=3 instance driven from a step table with a
// scoreboard of expected array-edge beats, plus a DIM=1 instance for the single-lane case.
module tb_systolic_skew_feeder;

    localparam int unsigned W = 8;
    localparam int unsigned D = 3;
`ifdef SKEW_TILE_CHECK_EN
    localparam logic ExpErr = 1'b1;
`else
    localparam logic ExpErr = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_last, in_ready, out_en, done, tile_err;
    logic [D*W-1:0] in_data, out_data;
    logic           d1_valid, d1_last, d1_ready, d1_en, d1_done, d1_err;
    logic [W-1:0]   d1_data, d1_out;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.DIM(D), .BITS_AB(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .in_data  (in_data),
        .out_data (out_data),
        .out_en   (out_en),
        .done     (done),
        .tile_err (tile_err)
    );

    systolic_skew_feeder #(.DIM(1), .BITS_AB(W)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (d1_valid),
        .in_ready (d1_ready),
        .in_last  (d1_last),
        .in_data  (d1_data),
        .out_data (d1_out),
        .out_en   (d1_en),
        .done     (d1_done),
        .tile_err (d1_err)
    );

    typedef struct {
        logic         v;
        logic         l;
        logic [W-1:0] a0, a1, a2;
        logic         en;
        logic [W-1:0] e0, e1, e2;
        logic         dn;
        logic         rdy;
    } step_t;

    typedef struct {
        logic [D*W-1:0] data;
        logic           dn;
    } exp_t;

    step_t          tbl[$];
    exp_t           sb[$];
    logic [D*W-1:0] last_out;
    bit             mon_on = 1'b0;
    int             checks = 0;
    int             failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic step_t mk(input logic v, input logic l,
                                 input logic [W-1:0] a0, input logic [W-1:0] a1,
                                 input logic [W-1:0] a2, input logic en,
                                 input logic [W-1:0] e0, input logic [W-1:0] e1,
                                 input logic [W-1:0] e2, input logic dn, input logic rdy);
        step_t s;
        s.v = v; s.l = l; s.a0 = a0; s.a1 = a1; s.a2 = a2;
        s.en = en; s.e0 = e0; s.e1 = e1; s.e2 = e2; s.dn = dn; s.rdy = rdy;
        return s;
    endfunction

    // Scoreboard consumer: every out_en beat pops one expectation; idle cycles must hold data.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_out = '0;
        end else if (mon_on) begin
            if (out_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_en: got out_en=1 data=%0h expected no beat",
                             out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("done_with_en", 32'(done), 32'(e.dn));
                    last_out = e.data;
                end
            end else begin
                check("held_data", 32'(out_data), 32'(last_out));
                check("done_idle", 32'(done), 32'(0));
            end
        end
    end

    // Call at a negedge; each step's expected beat appears after the following posedge.
    task automatic run_steps(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            step_t s;
            s = tbl[i];
            check($sformatf("in_ready[%0d]", i), 32'(in_ready), 32'(s.rdy));
            in_valid = s.v;
            in_last  = s.l;
            in_data  = {s.a2, s.a1, s.a0};
            if (s.en) sb.push_back('{data: {s.e2, s.e1, s.e0}, dn: s.dn});
            @(negedge clk);
        end
        #1;
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(sb.size()), 32'(0));
    endtask

    int s1_lo, s1_hi, s2_lo, s2_hi, s3_lo, s3_hi, s4_lo, s4_hi, s6_lo, s6_mid, s6_hi;

    initial begin
        // Scenario 1: three full rows, valid held high.
        s1_lo = tbl.size();
        tbl.push_back(mk(1, 0, 1, 2, 3, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4, 5, 6, 1, 4, 2, 0, 0, 1));
        tbl.push_back(mk(1, 1, 7, 8, 9, 1, 7, 5, 3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 9, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        s1_hi = tbl.size();
        // Scenario 2: two bubbles between beats 1 and 2.
        s2_lo = tbl.size();
        tbl.push_back(mk(1, 0, 1, 2, 3, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4, 5, 6, 1, 4, 2, 0, 0, 1));
        tbl.push_back(mk(1, 1, 7, 8, 9, 1, 7, 5, 3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 9, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        s2_hi = tbl.size();
        // Scenario 3: back-to-back tiles, second one signed negative.
        s3_lo = tbl.size();
        tbl.push_back(mk(1, 0, 1, 2, 3, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4, 5, 6, 1, 4, 2, 0, 0, 1));
        tbl.push_back(mk(1, 1, 7, 8, 9, 1, 7, 5, 3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 9, 1, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 8'hFE, 8'hFD, 1, 8'hFF, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 8'hFF, 8'hFE, 8'hFD, 1, 8'hFF, 8'hFE, 0, 0, 1));
        tbl.push_back(mk(1, 1, 8'hFF, 8'hFE, 8'hFD, 1, 8'hFF, 8'hFE, 8'hFD, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'hFE, 8'hFD, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 8'hFD, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        s3_hi = tbl.size();
        // Scenario 4: two beats, then reset.
        s4_lo = tbl.size();
        tbl.push_back(mk(1, 0, 1, 2, 3, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4, 5, 6, 1, 4, 2, 0, 0, 1));
        s4_hi = tbl.size();
        // Scenario 6: short tile, last on beat 2.
        s6_lo = tbl.size();
        tbl.push_back(mk(1, 0, 1, 2, 3, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 4, 5, 6, 1, 4, 2, 0, 0, 1));
        s6_mid = tbl.size();
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 5, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 6, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        s6_hi = tbl.size();

        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        d1_valid = 1'b0; d1_last = 1'b0; d1_data = '0;
        repeat (2) @(negedge clk);
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_en", 32'(out_en), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_tile_err", 32'(tile_err), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_d1_in_ready", 32'(d1_ready), 32'(0));
        rst_n = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);

        run_steps(s1_lo, s1_hi);
        check_drained("s1_drained");
        check("s1_tile_err", 32'(tile_err), 32'(0));

        run_steps(s2_lo, s2_hi);
        check_drained("s2_drained");

        run_steps(s3_lo, s3_hi);
        check_drained("s3_drained");
        check("s3_tile_err", 32'(tile_err), 32'(0));

        // Scenario 4: reset mid-tile.
        run_steps(s4_lo, s4_hi);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("s4_rst_out_data", 32'(out_data), 32'(0));
        check("s4_rst_out_en", 32'(out_en), 32'(0));
        check("s4_rst_done", 32'(done), 32'(0));
        check("s4_rst_in_ready", 32'(in_ready), 32'(0));
        sb.delete();
        last_out = '0;
        repeat (2) begin
            @(negedge clk);
            check("s4_no_done", 32'(done), 32'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_steps(s1_lo, s1_hi);
        check_drained("s4_after_drained");

        // Scenario 5: single-lane instance.
        check("s5_ready0", 32'(d1_ready), 32'(1));
        d1_valid = 1'b1; d1_last = 1'b1; d1_data = 8'd5;
        @(negedge clk);
        check("s5_out_data", 32'(d1_out), 32'(5));
        check("s5_out_en", 32'(d1_en), 32'(1));
        check("s5_done", 32'(d1_done), 32'(1));
        check("s5_ready1", 32'(d1_ready), 32'(1));
        d1_valid = 1'b0; d1_last = 1'b0;
        @(negedge clk);
        check("s5_out_en_off", 32'(d1_en), 32'(0));
        check("s5_done_off", 32'(d1_done), 32'(0));
        check("s5_held", 32'(d1_out), 32'(5));
        check("s5_ready2", 32'(d1_ready), 32'(1));
        check("s5_tile_err", 32'(d1_err), 32'(0));

        // Scenario 6: short tile; error flag depends on build.
        run_steps(s6_lo, s6_mid);
        check("s6_err_after_beat", 32'(tile_err), 32'(ExpErr));
        run_steps(s6_mid, s6_hi);
        check_drained("s6_drained");
        check("s6_err_sticky", 32'(tile_err), 32'(ExpErr));
        run_steps(s1_lo, s1_hi);
        check_drained("s6_good_drained");
        check("s6_err_still", 32'(tile_err), 32'(ExpErr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream feeder for the tpumac systolic array.
- Accepts one DIM-wide row vector of signed A (or B) operands per handshake beat.
- Re-times the row diagonally so lane i reaches the array i cycles after lane 0, then appends zero-padding beats to drain the diagonal.
- Generates the array-wide `en` strobe and a tile-done pulse.

Parameters:
- DIM, 8, number of lanes (array edge length); legal range 1..16.
- BITS_AB, 8, operand width per lane (signed, matches tpumac Ain/Bin).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream row beat valid.
- in_ready  output  1  feeder can accept a beat.
- in_last  input  1  qualifies the final beat of a tile.
- in_data  input  DIM*BITS_AB  packed row; lane i = bits [i*BITS_AB +: BITS_AB].
- out_data  output  DIM*BITS_AB  skewed lanes to the array edge (Ain/Bin of the first row/column).
- out_en  output  1  array enable; high in the cycle out_data is to be consumed.
- done  output  1  one-cycle pulse after the final drain beat.
- tile_err  output  1  sticky tile-length error (see Optional Feature).

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; all skew registers clear to 0.
  - out_data = 0, out_en = 0, done = 0, tile_err = 0.
  - in_ready is 0 while rst_n is low and 1 on the first cycle after release.
  - Reset mid-tile discards all in-flight data; no done pulse is produced.
- Lane i is a shift register of depth i+1:
  - Lane 0 latency is 1 cycle; lane i latency is i+1 advance cycles.
  - All lanes shift together only on an advance cycle and hold otherwise.
- advance = (in_valid && in_ready) || (state == FLUSH).
  - In FLUSH, every lane input is 0.
- out_en is registered from advance, so it is high exactly in the cycles following an advance edge.
- States:
  - IDLE: in_ready = 1. Accepted beat with in_last = 0 → STREAM. Accepted beat with in_last = 1 → FLUSH, or → IDLE with done if DIM == 1.
  - STREAM: in_ready = 1. No in_valid means a bubble: no shift, out_en = 0 next cycle, data held. Accepted beat with in_last = 1 → FLUSH (or IDLE with done if DIM == 1).
  - FLUSH: in_ready = 0. Runs exactly DIM-1 advance cycles, counted by flush_cnt (clog2(DIM) bits, loaded 0, terminal at DIM-2). On terminal → IDLE; done is registered high for one cycle, coincident with the last out_en.
- in_ready is combinational from state only. It never depends on in_valid.
- Back-to-back tiles: a new beat is acceptable in the first IDLE cycle after done.
- Data is not modified; widths pass through, sign preserved. out_data holds its last value when out_en = 0.
- A beat counter (clog2(DIM+1) bits) counts accepted beats per tile and clears on entry to IDLE.

Optional Feature:
- Macro: SKEW_TILE_CHECK_EN.
- Defined:
  - If in_last is accepted with beat count + 1 != DIM, tile_err sets and stays set until reset.
  - If DIM beats are accepted without in_last, tile_err also sets; the feeder continues in STREAM until in_last.
  - Data flow is unaffected in both cases.
- Undefined: tile_err is tied to 0 and the beat counter is not synthesised.

Decomposition:
- Shared package tpu_pkg:
  - Constants DIM_DEFAULT = 8, BITS_AB = 8, BITS_C = 16.
  - feeder_state_t enum {IDLE, STREAM, FLUSH}.
  - Shared with the array, tpumac and future drain/collector stages.
- One sub-module, skew_lane:
  - Parameters DEPTH and BITS_AB.
  - Ports clk, rst_n, adv, d, q.
  - Generated DIM times with DEPTH = i+1.
- FSM, counters and out_en/done registers stay in the top level.

Test Plan:
1. DIM=3, rows {1,2,3},{4,5,6},{7,8,9}, in_valid held high, last on the third beat. Per out_en cycle, lanes (0,1,2) must be: (1,0,0), (4,2,0), (7,5,3), (0,8,6), (0,0,9). done is high with the fifth; in_ready is low for exactly 2 cycles.
2. Same tile with in_valid low for 2 cycles between beats 1 and 2 → two out_en = 0 gaps, out_data held at (1,0,0), then the same sequence as scenario 1.
3. Two tiles back-to-back, second rows {-1,-2,-3}×3 (signed 8'hFF…) → second sequence starts the cycle after done; lane 2 shows 8'hFD on its final beat.
4. Assert rst_n low after beat 2 of a DIM=3 tile → all outputs 0 immediately; no done; the next tile behaves as in scenario 1.
5. DIM=1, single beat {5} with last → out_data = 5, out_en = 1 and done = 1 in the same cycle; in_ready never drops.
6. With SKEW_TILE_CHECK_EN, DIM=3, last on beat 2 → tile_err = 1 the cycle after that beat and stays 1. Without the macro, tile_err stays 0.
